// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared multi-cycle ALU.
// Grants one operation at a time, round-robin on contention, and returns the result to its owner.
module alu_arbiter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_src1,
  input  logic [WIDTH-1:0] req0_src2,
  input  logic [2:0]       req0_ctr,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_src1,
  input  logic [WIDTH-1:0] req1_src2,
  input  logic [2:0]       req1_ctr,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero_bit,
  output logic             busy,
  output logic             grant_id
);

  localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q;
  logic             grant_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic [2:0]       ctr_q;
  logic [WIDTH-1:0] res0_q, res1_q;
  logic             zero0_q, zero1_q;

  logic sel;
  logic accept;
  logic handshake;

  always_comb begin
    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    sel       = (req0_valid && req1_valid) ? prio_q : req1_valid;
    accept    = !reset && (state_q == StIdle) && (req0_valid || req1_valid);
    handshake = (state_q == StResp) && (grant_q ? resp1_ready : resp0_ready);

    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  if (cnt_q == 4'd0) state_d = StResp;
      StResp:  if (handshake) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted, even before the reset edge.
  always_comb begin
    req0_ready  = accept && !sel;
    req1_ready  = accept && sel;
    resp0_valid = !reset && (state_q == StResp) && !grant_q;
    resp1_valid = !reset && (state_q == StResp) && grant_q;
    busy        = !reset && (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= 4'd0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctr_q   <= 3'd0;
      res0_q  <= '0;
      res1_q  <= '0;
      zero0_q <= 1'b0;
      zero1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src1_q  <= sel ? req1_src1 : req0_src1;
        src2_q  <= sel ? req1_src2 : req0_src2;
        ctr_q   <= sel ? req1_ctr : req0_ctr;
        grant_q <= sel;
        cnt_q   <= CntLoad;
      end
      if (state_q == StExec) begin
        if (cnt_q == 4'd0) begin
          if (grant_q) begin
            res1_q  <= alu_result;
            zero1_q <= zero_bit;
          end else begin
            res0_q  <= alu_result;
            zero0_q <= zero_bit;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
      if (handshake) prio_q <= ~grant_q;
    end
  end

  assign alu_src1     = src1_q;
  assign alu_src2     = src2_q;
  assign alu_ctr      = ctr_q;
  assign grant_id     = grant_q;
  assign resp0_result = res0_q;
  assign resp0_zero   = zero0_q;
  assign resp1_result = res1_q;
  assign resp1_zero   = zero1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with a 1-cycle ALU, one with a 4-cycle ALU.
// Both share request stimulus; each scenario resets first and checks only the instance it targets.
module tb_alu_arbiter;

  localparam logic [2:0] CtrAdd = 3'b010;
  localparam logic [2:0] CtrSub = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [2:0]  req0_ctr, req1_ctr;

  logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero;
  logic [31:0] resp0_result, resp1_result, alu_src1, alu_src2, alu_result;
  logic [2:0]  alu_ctr;
  logic        zero_bit, busy, grant_id;

  logic        d4_req0_ready, d4_req1_ready, d4_resp0_valid, d4_resp1_valid;
  logic        d4_resp0_zero, d4_resp1_zero;
  logic [31:0] d4_resp0_result, d4_resp1_result, d4_alu_src1, d4_alu_src2, d4_alu_result;
  logic [2:0]  d4_alu_ctr;
  logic        d4_zero_bit, d4_busy, d4_grant_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result    = alu_f(alu_ctr, alu_src1, alu_src2);
  assign zero_bit      = (alu_result == 32'd0);
  assign d4_alu_result = alu_f(d4_alu_ctr, d4_alu_src1, d4_alu_src2);
  assign d4_zero_bit   = (d4_alu_result == 32'd0);

  alu_arbiter #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_ctr(req0_ctr),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_ctr(req1_ctr),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .zero_bit(zero_bit), .busy(busy), .grant_id(grant_id)
  );

  alu_arbiter #(.WIDTH(32), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(d4_req0_ready), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_ctr(req0_ctr),
    .resp0_valid(d4_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(d4_resp0_result),
    .resp0_zero(d4_resp0_zero),
    .req1_valid(req1_valid), .req1_ready(d4_req1_ready), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_ctr(req1_ctr),
    .resp1_valid(d4_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(d4_resp1_result),
    .resp1_zero(d4_resp1_zero),
    .alu_src1(d4_alu_src1), .alu_src2(d4_alu_src2), .alu_ctr(d4_alu_ctr),
    .alu_result(d4_alu_result), .zero_bit(d4_zero_bit), .busy(d4_busy),
    .grant_id(d4_grant_id)
  );

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_src1 = 0; req0_src2 = 0; req0_ctr = 0;
    req1_src1 = 0; req1_src2 = 0; req1_ctr = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1; req0_src1 = 32'h55; req0_ctr = CtrAdd;
    tick();
    tick();
    checks++;
    if ({req0_ready, req1_ready, busy, resp0_valid, resp1_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b want 00000",
               {req0_ready, req1_ready, busy, resp0_valid, resp1_valid});
    end
    checks++;
    if ({alu_src1, alu_src2, alu_ctr, grant_id} !== 68'd0) begin
      errors++;
      $display("FAIL reset_alu_regs: got src1=%0h src2=%0h ctr=%0h grant=%0b want all 0",
               alu_src1, alu_src2, alu_ctr, grant_id);
    end
    checks++;
    if ({resp0_result, resp1_result, resp0_zero, resp1_zero} !== 66'd0) begin
      errors++;
      $display("FAIL reset_results: got r0=%0h r1=%0h z0=%0b z1=%0b want all 0",
               resp0_result, resp1_result, resp0_zero, resp1_zero);
    end
    reset = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single;
    do_reset();
    req0_valid = 1; req0_src1 = 5; req0_src2 = 7; req0_ctr = CtrAdd; resp0_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    tick();
    checks++;
    if (req0_ready !== 1'b0 || busy !== 1'b1 || alu_src1 !== 32'd5 || alu_src2 !== 32'd7
        || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL single_exec: got ready=%b busy=%b src1=%0d src2=%0d grant=%b want 0 1 5 7 0",
               req0_ready, busy, alu_src1, alu_src2, grant_id);
    end
    req0_valid = 0;
    tick();
    checks++;
    if (resp0_valid !== 1'b1 || resp0_result !== 32'd12 || resp0_zero !== 1'b0
        || resp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got v0=%b res=%0d z=%b v1=%b want 1 12 0 0",
               resp0_valid, resp0_result, resp0_zero, resp1_valid);
    end
    tick();
    checks++;
    if (resp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got v0=%b busy=%b want 0 0", resp0_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic exp;
    logic got;
    do_reset();
    req0_valid = 1; req0_src1 = 1;  req0_src2 = 2; req0_ctr = CtrAdd;
    req1_valid = 1; req1_src1 = 10; req1_src2 = 3; req1_ctr = CtrSub;
    resp0_ready = 1; resp1_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = i[0];
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        if (req0_ready || req1_ready) got = 1'b1;
        else tick();
      end
      checks++;
      if (!got || req1_ready !== exp || req0_ready !== !exp) begin
        errors++;
        $display("FAIL b2b_grant%0d: got r0=%b r1=%b seen=%b want r1=%b", i, req0_ready,
                 req1_ready, got, exp);
      end
      tick();
      checks++;
      if (grant_id !== exp) begin
        errors++;
        $display("FAIL b2b_grant_id%0d: got %b want %b", i, grant_id, exp);
      end
      tick();
      checks++;
      if (exp ? (resp1_valid !== 1'b1 || resp1_result !== 32'd7 || resp0_valid !== 1'b0)
              : (resp0_valid !== 1'b1 || resp0_result !== 32'd3 || resp1_valid !== 1'b0)) begin
        errors++;
        $display("FAIL b2b_resp%0d: got v0=%b r0=%0d v1=%b r1=%0d want owner %b (3 / 7)", i,
                 resp0_valid, resp0_result, resp1_valid, resp1_result, exp);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    req1_valid = 1; req1_src1 = 20; req1_src2 = 22; req1_ctr = CtrAdd; resp1_ready = 0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL lone_req1: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_src1 = 4; req0_src2 = 4; req0_ctr = CtrAdd; resp0_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_exec_ready: got %b want 0", req0_ready);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({resp1_valid, resp1_result, busy, req0_ready} !== {1'b1, 32'd42, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall%0d: got v1=%b res=%0d busy=%b r0=%b want 1 42 1 0", i,
                 resp1_valid, resp1_result, busy, req0_ready);
      end
      tick();
    end
    resp1_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || resp1_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got r0=%b v1=%b want 0 1", req0_ready, resp1_valid);
    end
    tick();
    checks++;
    if (resp1_valid !== 1'b0 || req0_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_after: got v1=%b r0=%b busy=%b want 0 1 0", resp1_valid, req0_ready,
               busy);
    end
    tick();
    req0_valid = 0;
    tick();
    checks++;
    if (resp0_valid !== 1'b1 || resp0_result !== 32'd8) begin
      errors++;
      $display("FAIL bp_req0_resp: got v0=%b res=%0d want 1 8", resp0_valid, resp0_result);
    end
    tick();
  endtask

  task automatic test_exec4;
    do_reset();
    req0_valid = 1; req0_src1 = 9; req0_src2 = 9; req0_ctr = CtrSub; resp0_ready = 1;
    #1;
    checks++;
    if (d4_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL exec4_ready: got %b want 1", d4_req0_ready);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) req0_valid = 0;
      checks++;
      if (k < 5) begin
        if (d4_resp0_valid !== 1'b0 || d4_busy !== 1'b1) begin
          errors++;
          $display("FAIL exec4_cycle%0d: got v0=%b busy=%b want 0 1", k, d4_resp0_valid,
                   d4_busy);
        end
      end else if (d4_resp0_valid !== 1'b1 || d4_resp0_result !== 32'd0
                   || d4_resp0_zero !== 1'b1) begin
        errors++;
        $display("FAIL exec4_resp: got v0=%b res=%0d z=%b want 1 0 1", d4_resp0_valid,
                 d4_resp0_result, d4_resp0_zero);
      end
    end
    tick();
    checks++;
    if (d4_resp0_valid !== 1'b0 || d4_alu_src1 !== 32'd9 || d4_alu_ctr !== CtrSub) begin
      errors++;
      $display("FAIL exec4_hold: got v0=%b src1=%0d ctr=%0h want 0 9 %0h", d4_resp0_valid,
               d4_alu_src1, d4_alu_ctr, CtrSub);
    end
  endtask

  task automatic test_reset_in_exec;
    logic seen0;
    logic seen1;
    do_reset();
    req0_valid = 1; req0_src1 = 1; req0_src2 = 1; req0_ctr = CtrAdd; resp0_ready = 1;
    tick();
    req0_valid = 0;
    tick();
    reset = 1;
    req1_valid = 1; req1_src1 = 6; req1_src2 = 7; req1_ctr = CtrAdd; resp1_ready = 1;
    #1;
    checks++;
    if ({d4_req1_ready, d4_req0_ready, d4_busy, d4_resp0_valid, d4_resp1_valid} !== 5'b0) begin
      errors++;
      $display("FAIL rst_exec_during: got %b want 00000",
               {d4_req1_ready, d4_req0_ready, d4_busy, d4_resp0_valid, d4_resp1_valid});
    end
    tick();
    checks++;
    if ({d4_alu_src1, d4_alu_src2, d4_alu_ctr, d4_grant_id, d4_resp0_result} !== 100'd0) begin
      errors++;
      $display("FAIL rst_exec_regs: got src1=%0h src2=%0h ctr=%0h grant=%b r0=%0h want 0",
               d4_alu_src1, d4_alu_src2, d4_alu_ctr, d4_grant_id, d4_resp0_result);
    end
    reset = 0;
    #1;
    checks++;
    if (d4_req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_accept: got %b want 1", d4_req1_ready);
    end
    seen0 = 0;
    seen1 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) req1_valid = 0;
      seen0 |= d4_resp0_valid;
      if (d4_resp1_valid === 1'b1 && d4_resp1_result === 32'd13) seen1 = 1;
    end
    checks++;
    if (seen0 !== 1'b0 || seen1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_after: got resp0_seen=%b resp1_13_seen=%b want 0 1", seen0,
               seen1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_exec4();
    test_reset_in_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 32, operand/result width; matches the shared ALU.
- EXEC_CYCLES, 1, ALU settle cycles before capture; legal range 1..15.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- req0_valid, input, 1, requester 0 operation pending.
- req0_ready, output, 1, requester 0 operation accepted this cycle.
- req0_src1, req0_src2, input, WIDTH, requester 0 operands.
- req0_ctr, input, 3, requester 0 ALU control code.
- resp0_valid, output, 1, requester 0 result available.
- resp0_ready, input, 1, requester 0 consumes result.
- resp0_result, output, WIDTH, requester 0 ALU result.
- resp0_zero, output, 1, requester 0 zero flag.
- req1_* and resp1_*, same directions and widths as the requester 0 ports, for requester 1.
- alu_src1, alu_src2, output, WIDTH, operands driven to the shared ALU.
- alu_ctr, output, 3, control code driven to the shared ALU.
- alu_result, input, WIDTH, ALU result.
- zero_bit, input, 1, ALU zero flag.
- busy, output, 1, high in any state other than IDLE.
- grant_id, output, 1, requester owning the current operation.

REQ-003 Clock is clk and reset is reset: one clock, synchronous active-high reset.

Function
REQ-004 The FSM SHALL have three states, IDLE, EXEC and RESP, encoded in 2 bits, with the fourth code returning to IDLE.
REQ-005 IDLE, no reqN_valid: remain in IDLE with all readys low.
REQ-006 IDLE, exactly one reqN_valid: grant N regardless of the priority pointer.
REQ-007 IDLE, both valid: grant the requester named by the 1-bit priority pointer prio.
REQ-008 reqN_ready SHALL be combinational: high only in IDLE for the granted N, so at most one ready is high per cycle.
REQ-009 On the accept edge the block SHALL:
- latch src1, src2 and ctr into the alu_* output registers;
- set grant_id = N;
- load the settle counter with EXEC_CYCLES-1;
- go to EXEC.
REQ-010 alu_src1, alu_src2 and alu_ctr SHALL be registered and SHALL hold their value outside the accept edge; they are not cleared after an operation.
REQ-011 EXEC SHALL decrement the counter each cycle. In the cycle the counter is 0, alu_result and zero_bit SHALL be captured into the result registers and the FSM SHALL go to RESP. EXEC therefore lasts exactly EXEC_CYCLES cycles.
REQ-012 RESP SHALL hold respN_valid high for N = grant_id; the other respN_valid SHALL be low.
REQ-013 respN_result and respN_zero SHALL show the captured values while respN_valid is high, and SHALL stay stable until the handshake completes.
REQ-014 RESP with respN_ready high SHALL, on that edge:
- go to IDLE;
- set prio = ~grant_id;
- drop respN_valid in the next cycle.
REQ-015 RESP with respN_ready low SHALL hold the state; a stall of any length SHALL leave all outputs unchanged.
REQ-016 Requests arriving in EXEC or RESP SHALL get ready low and SHALL wait. Requesters hold valid and operands until ready; the block SHALL NOT drop a pending valid.
REQ-017 Latency: accept at edge T gives respN_valid high from cycle T+1+EXEC_CYCLES. Peak throughput is one operation per EXEC_CYCLES+2 cycles.
REQ-018 A requester whose valid stays high with no gap after its own response SHALL NOT be granted twice in a row while the other requester is valid.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 The block SHALL pass data without modification: no interpretation of ctr codes, no arithmetic on operands or results.

Reset
REQ-021 While reset is high at a clock edge, the block SHALL set:
- state = IDLE;
- prio = 0;
- grant_id = 0;
- settle counter = 0;
- alu_src1 = alu_src2 = 0, alu_ctr = 0;
- resp0_result = resp1_result = 0, resp0_zero = resp1_zero = 0.
REQ-022 While reset is high, all valid/ready outputs and busy SHALL be 0.
REQ-023 Reset during EXEC or RESP SHALL drop the operation in progress; no response is issued for it.
REQ-024 On the first cycle after reset deasserts, the block SHALL be able to accept a request.

Verification
REQ-025 Single request, EXEC_CYCLES=1, requester 0: ctr=add code, src1=5, src2=7 held valid, resp0_ready=1 -> req0_ready high for one cycle; resp0_valid high 2 cycles later with resp0_result=12 and resp0_zero=0 as driven by the ALU model.
REQ-026 Simultaneous requests after reset: both valid -> requester 0 granted first, then requester 1; grant_id sequence 0,1,0,1 over four back-to-back operations.
REQ-027 Back-pressure: resp1_ready low for 10 cycles -> resp1_valid, resp1_result and busy stable for all 10 cycles. req0 held valid gets no ready until one cycle after the resp1 handshake.
REQ-028 EXEC_CYCLES=4: accept at edge T -> capture exactly at the 4th EXEC cycle and respN_valid from T+5. Sub of 9-9 -> resp_zero=1, result=0.
REQ-029 Reset in the middle of EXEC: no respN_valid ever appears for that operation. All outputs are 0 in the cycle after reset. A new request is accepted on the first cycle after deassert.
REQ-030 Lone requester: only req1_valid asserted while prio=0 -> req1 is granted immediately, with no idle bubble.
